wakeup_latency_pipe: RTL

WAKEUP_LATENCY_PIPE -- requirements
Module: wakeup_latency_pipe

---
 rtl/wakeup_latency_pipe_pkg.sv | 14 +
 rtl/wakeup_latency_lane.sv | 79 +++++++
 rtl/wakeup_latency_pipe.sv | 53 +++++
 3 files changed

// File: rtl/wakeup_latency_pipe_pkg.sv
// Shared scheduler types: the design-wide latency ceiling and the latency
// field type used by issue logic.
package SchedulerTypes;

  localparam int WAKEUP_MAX_LATENCY = 4;
  localparam int ISSUE_LATENCY_WIDTH = $clog2(WAKEUP_MAX_LATENCY + 1);

  typedef logic [ISSUE_LATENCY_WIDTH-1:0] IssueLatencyPath;

  function automatic logic isLegalLatency(input int lat, input int maxLat);
    return (lat >= 1) && (lat <= maxLat);
  endfunction

endpackage

// File: rtl/wakeup_latency_lane.sv
// One issue lane: a MAX_LATENCY-deep shifter of {valid, regNum}, where slot k
// broadcasts in k+1 cycles, plus the slot-free vector and an error pulse.
module wakeup_latency_lane
  import SchedulerTypes::*;
#(
  parameter int MAX_LATENCY       = WAKEUP_MAX_LATENCY,
  parameter int REG_NUM_BIT_WIDTH = 7
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               issue,
  input  logic                               issueDstValid,
  input  logic [REG_NUM_BIT_WIDTH-1:0]       issueDstRegNum,
  input  logic [$clog2(MAX_LATENCY+1)-1:0]   issueLatency,
  output logic [MAX_LATENCY-1:0]             slotFree,
  output logic                               wakeup,
  output logic                               wakeupDstValid,
  output logic [REG_NUM_BIT_WIDTH-1:0]       wakeupDstRegNum,
  output logic                               errorPulse
);

  typedef logic [REG_NUM_BIT_WIDTH-1:0] RegNumPath;

  logic [MAX_LATENCY-1:0] slotValid;
  RegNumPath              slotRegNum [MAX_LATENCY];
  logic                   latLegal;
  logic                   targetFree;
  logic                   active;
  logic                   accept;

  // Slot L-1 becomes slot L's shifted content next cycle, so it is free
  // exactly when slot L is empty; the top slot always shifts in empty.
  for (genvar k = 0; k < MAX_LATENCY; k++) begin : g_free
    if (k == MAX_LATENCY - 1) begin : g_top
      assign slotFree[k] = 1'b1;
    end else begin : g_mid
      assign slotFree[k] = !slotValid[k+1];
    end
  end

  always_comb begin
    targetFree = 1'b0;
    for (int k = 0; k < MAX_LATENCY; k++) begin
      if (int'(issueLatency) == k + 1) targetFree = slotFree[k];
    end
  end

  assign latLegal   = isLegalLatency(int'(issueLatency), MAX_LATENCY);
  assign active     = issue && issueDstValid && !rst && !flush;
  assign accept     = active && latLegal && targetFree;
  assign errorPulse = active && !(latLegal && targetFree);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slotValid <= '0;
    end else begin
      slotValid <= slotValid >> 1;
      for (int k = 0; k < MAX_LATENCY; k++) begin
        if (accept && (int'(issueLatency) == k + 1)) slotValid[k] <= 1'b1;
      end
    end
  end

  // Register numbers are qualified by slotValid, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_LATENCY - 1; k++) begin
      slotRegNum[k] <= slotRegNum[k+1];
    end
    for (int k = 0; k < MAX_LATENCY; k++) begin
      if (accept && (int'(issueLatency) == k + 1)) slotRegNum[k] <= issueDstRegNum;
    end
  end

  assign wakeup          = slotValid[0];
  assign wakeupDstValid  = slotValid[0];
  assign wakeupDstRegNum = slotRegNum[0];

endmodule

// File: rtl/wakeup_latency_pipe.sv
// Fixed-latency wakeup pipeline: one slot shifter per issue lane feeding the
// ready bit table, with a sticky flag for illegal latencies and collisions.
module wakeup_latency_pipe
  import SchedulerTypes::*;
#(
  parameter int ISSUE_WIDTH       = 2,
  parameter int MAX_LATENCY       = WAKEUP_MAX_LATENCY,
  parameter int REG_NUM_BIT_WIDTH = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [ISSUE_WIDTH-1:0]            issue,
  input  logic [ISSUE_WIDTH-1:0]            issueDstValid,
  input  logic [REG_NUM_BIT_WIDTH-1:0]      issueDstRegNum [ISSUE_WIDTH],
  input  logic [$clog2(MAX_LATENCY+1)-1:0]  issueLatency [ISSUE_WIDTH],
  output logic [MAX_LATENCY-1:0]            latencySlotFree [ISSUE_WIDTH],
  output logic [ISSUE_WIDTH-1:0]            wakeup,
  output logic [ISSUE_WIDTH-1:0]            wakeupDstValid,
  output logic [REG_NUM_BIT_WIDTH-1:0]      wakeupDstRegNum [ISSUE_WIDTH],
  output logic                              conflictError
);

  // issue is a one-cycle strobe with no backpressure: the scheduler must
  // consult latencySlotFree before issuing; a refused op is dropped and flagged.
  logic [ISSUE_WIDTH-1:0] errorPulse;

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
    wakeup_latency_lane #(
      .MAX_LATENCY      (MAX_LATENCY),
      .REG_NUM_BIT_WIDTH(REG_NUM_BIT_WIDTH)
    ) u_lane (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .issue          (issue[i]),
      .issueDstValid  (issueDstValid[i]),
      .issueDstRegNum (issueDstRegNum[i]),
      .issueLatency   (issueLatency[i]),
      .slotFree       (latencySlotFree[i]),
      .wakeup         (wakeup[i]),
      .wakeupDstValid (wakeupDstValid[i]),
      .wakeupDstRegNum(wakeupDstRegNum[i]),
      .errorPulse     (errorPulse[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) conflictError <= 1'b0;
    else     conflictError <= conflictError | (|errorPulse);
  end

endmodule
